// File: rtl/dispatcher_pkg.sv
// Shared types and FETCH geometry for the dispatcher BRAM write side.
package dispatcher_pkg;

    localparam int unsigned EXP_LINES       = 16;
    localparam int unsigned MAN_LINES       = 512;
    localparam int unsigned LINES_PER_FETCH = 528;
    localparam int unsigned BYTES_PER_LINE  = 32;
    localparam int unsigned MAN_BASE_ADDR   = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_EXP,
        FETCH_MAN,
        UNPACK_DRAIN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/dispatcher_exp_unpacker.sv
// Walks the 512 packed exponent bytes through the BRAM's combinational packed-read
// port and emits one registered aligned-exponent write per cycle on the target side.
module dispatcher_exp_unpacker
    import dispatcher_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic                  target_i,
    input  logic [DATA_WIDTH-1:0] exp_packed_rd_data_i,
    output logic [3:0]            exp_packed_rd_addr_o,
    output logic [8:0]            left_addr_o,
    output logic [7:0]            left_data_o,
    output logic                  left_en_o,
    output logic [8:0]            right_addr_o,
    output logic [7:0]            right_data_o,
    output logic                  right_en_o,
    output logic                  unpack_done_o
);

    logic [9:0] u_q, u_d;
    logic       active_q, active_d;
    logic       done_q, done_d;
    logic [8:0] al_addr_q;
    logic [7:0] al_data_q;
    logic       left_en_q, right_en_q;
    logic [7:0] sel_byte;

    assign sel_byte = exp_packed_rd_data_i[{u_q[4:0], 3'b000} +: 8];

    always_comb begin
        u_d      = u_q;
        active_d = active_q;
        done_d   = done_q;
        if (clear_i) begin
            u_d      = '0;
            active_d = 1'b0;
            done_d   = 1'b0;
        end else if (start_i) begin
            u_d      = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            u_d = u_q + 10'd1;
            if (u_q == 10'(MAN_LINES - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    // done rises together with the final aligned write, so the FSM can leave on that cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            u_q        <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            al_addr_q  <= '0;
            al_data_q  <= '0;
            left_en_q  <= 1'b0;
            right_en_q <= 1'b0;
        end else begin
            u_q        <= u_d;
            active_q   <= active_d;
            done_q     <= done_d;
            left_en_q  <= active_q && !target_i;
            right_en_q <= active_q && target_i;
            if (active_q) begin
                al_addr_q <= u_q[8:0];
                al_data_q <= sel_byte;
            end
        end
    end

    assign exp_packed_rd_addr_o = u_q[8:5];
    assign left_addr_o          = al_addr_q;
    assign left_data_o          = al_data_q;
    assign left_en_o            = left_en_q;
    assign right_addr_o         = al_addr_q;
    assign right_data_o         = al_data_q;
    assign right_en_o           = right_en_q;
    assign unpack_done_o        = done_q;

endmodule

// File: rtl/dispatcher_fetch_writer.sv
// FETCH write engine: registers 528 stream lines onto the BRAM write port and
// runs the exponent unpacker once the packed-exponent lines are in the BRAM.
module dispatcher_fetch_writer
    import dispatcher_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned EXP_LINES  = 16,
    parameter int unsigned MAN_LINES  = 512
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_fetch_start,
    input  logic                  i_fetch_target,
    output logic                  o_fetch_busy,
    output logic                  o_fetch_done,
    input  logic [DATA_WIDTH-1:0] i_line_data,
    input  logic                  i_line_valid,
    output logic                  o_line_ready,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic                  o_wr_en,
    output logic                  o_wr_target,
    output logic [8:0]            o_left_exp_aligned_wr_addr,
    output logic [7:0]            o_left_exp_aligned_wr_data,
    output logic                  o_left_exp_aligned_wr_en,
    output logic [8:0]            o_right_exp_aligned_wr_addr,
    output logic [7:0]            o_right_exp_aligned_wr_data,
    output logic                  o_right_exp_aligned_wr_en,
    output logic [3:0]            o_exp_packed_rd_addr,
    output logic                  o_exp_packed_rd_target,
    input  logic [DATA_WIDTH-1:0] i_exp_packed_rd_data
);

    localparam int unsigned LINES = EXP_LINES + MAN_LINES;
    localparam int unsigned CW    = $clog2(LINES + 1);

    fetch_state_t state_q, state_d;

    logic [CW-1:0]         line_cnt_q;
    logic                  target_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  wr_en_q;

    logic accept;
    logic start_ok;
    logic last_exp_written;
    logic all_lines_written;
    logic unpack_done;

    assign accept   = i_line_valid && o_line_ready;
    assign start_ok = (state_q == IDLE) && i_fetch_start;

    // Unpack must wait until the last packed line has actually landed in the BRAM
    assign last_exp_written  = (state_q == FETCH_MAN) && wr_en_q
                               && (wr_addr_q == ADDR_WIDTH'(EXP_LINES - 1));
    assign all_lines_written = (line_cnt_q == CW'(LINES)) && !wr_en_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (i_fetch_start) state_d = FETCH_EXP;
            FETCH_EXP:    if (accept && (line_cnt_q == CW'(EXP_LINES - 1))) state_d = FETCH_MAN;
            FETCH_MAN:    if (all_lines_written) state_d = unpack_done ? DONE : UNPACK_DRAIN;
            UNPACK_DRAIN: if (unpack_done) state_d = DONE;
            DONE:         state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        o_fetch_busy = 1'b0;
        o_fetch_done = 1'b0;
        o_line_ready = 1'b0;
        case (state_q)
            FETCH_EXP, FETCH_MAN: begin
                o_fetch_busy = 1'b1;
                o_line_ready = (line_cnt_q < CW'(LINES));
            end
            UNPACK_DRAIN: o_fetch_busy = 1'b1;
            DONE:         o_fetch_done = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            line_cnt_q <= '0;
            target_q   <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                target_q   <= i_fetch_target;
                line_cnt_q <= '0;
            end else if (accept) begin
                line_cnt_q <= line_cnt_q + CW'(1);
            end
            wr_en_q <= accept;
            if (accept) begin
                wr_data_q <= i_line_data;
                wr_addr_q <= ADDR_WIDTH'(line_cnt_q);
            end
        end
    end

    assign o_wr_data              = wr_data_q;
    assign o_wr_addr              = wr_addr_q;
    assign o_wr_en                = wr_en_q;
    assign o_wr_target            = target_q;
    assign o_exp_packed_rd_target = target_q;

    dispatcher_exp_unpacker #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_unpacker (
        .clk_i                (i_clk),
        .rst_i                (i_reset),
        .clear_i              (start_ok),
        .start_i              (last_exp_written),
        .target_i             (target_q),
        .exp_packed_rd_data_i (i_exp_packed_rd_data),
        .exp_packed_rd_addr_o (o_exp_packed_rd_addr),
        .left_addr_o          (o_left_exp_aligned_wr_addr),
        .left_data_o          (o_left_exp_aligned_wr_data),
        .left_en_o            (o_left_exp_aligned_wr_en),
        .right_addr_o         (o_right_exp_aligned_wr_addr),
        .right_data_o         (o_right_exp_aligned_wr_data),
        .right_en_o           (o_right_exp_aligned_wr_en),
        .unpack_done_o        (unpack_done)
    );

endmodule

// File: tb/tb_dispatcher_fetch_writer.sv
// Randomized bench for dispatcher_fetch_writer against a cycle-schedule reference model.
module tb_dispatcher_fetch_writer;

    localparam int DW = 256;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_fetch_start;
    logic          i_fetch_target;
    logic          o_fetch_busy;
    logic          o_fetch_done;
    logic [DW-1:0] i_line_data;
    logic          i_line_valid;
    logic          o_line_ready;
    logic [DW-1:0] o_wr_data;
    logic [AW-1:0] o_wr_addr;
    logic          o_wr_en;
    logic          o_wr_target;
    logic [8:0]    o_left_exp_aligned_wr_addr;
    logic [7:0]    o_left_exp_aligned_wr_data;
    logic          o_left_exp_aligned_wr_en;
    logic [8:0]    o_right_exp_aligned_wr_addr;
    logic [7:0]    o_right_exp_aligned_wr_data;
    logic          o_right_exp_aligned_wr_en;
    logic [3:0]    o_exp_packed_rd_addr;
    logic          o_exp_packed_rd_target;
    logic [DW-1:0] i_exp_packed_rd_data;

    always #5 clk = ~clk;

    dispatcher_fetch_writer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .EXP_LINES (16),
        .MAN_LINES (512)
    ) dut (
        .i_clk                       (clk),
        .i_reset                     (i_reset),
        .i_fetch_start               (i_fetch_start),
        .i_fetch_target              (i_fetch_target),
        .o_fetch_busy                (o_fetch_busy),
        .o_fetch_done                (o_fetch_done),
        .i_line_data                 (i_line_data),
        .i_line_valid                (i_line_valid),
        .o_line_ready                (o_line_ready),
        .o_wr_data                   (o_wr_data),
        .o_wr_addr                   (o_wr_addr),
        .o_wr_en                     (o_wr_en),
        .o_wr_target                 (o_wr_target),
        .o_left_exp_aligned_wr_addr  (o_left_exp_aligned_wr_addr),
        .o_left_exp_aligned_wr_data  (o_left_exp_aligned_wr_data),
        .o_left_exp_aligned_wr_en    (o_left_exp_aligned_wr_en),
        .o_right_exp_aligned_wr_addr (o_right_exp_aligned_wr_addr),
        .o_right_exp_aligned_wr_data (o_right_exp_aligned_wr_data),
        .o_right_exp_aligned_wr_en   (o_right_exp_aligned_wr_en),
        .o_exp_packed_rd_addr        (o_exp_packed_rd_addr),
        .o_exp_packed_rd_target      (o_exp_packed_rd_target),
        .i_exp_packed_rd_data        (i_exp_packed_rd_data)
    );

    // Packed-exponent region of the BRAM, both sides, with combinational read
    logic [DW-1:0] bram_exp [2][16];
    always @(posedge clk)
        if (o_wr_en && o_wr_addr < 16) bram_exp[o_wr_target][o_wr_addr[3:0]] <= o_wr_data;
    assign i_exp_packed_rd_data = bram_exp[o_exp_packed_rd_target][o_exp_packed_rd_addr];

    int n_err = 0;
    int n_chk = 0;
    logic [DW-1:0] lines [528];

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_data"}, o_wr_data, '0);
        check({tag, "_outs"},
              {o_fetch_busy, o_fetch_done, o_line_ready, o_wr_addr, o_wr_en, o_wr_target,
               o_left_exp_aligned_wr_addr, o_left_exp_aligned_wr_data, o_left_exp_aligned_wr_en,
               o_right_exp_aligned_wr_addr, o_right_exp_aligned_wr_data, o_right_exp_aligned_wr_en,
               o_exp_packed_rd_addr, o_exp_packed_rd_target}, '0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            i_fetch_start = 1'b0;
            i_line_valid  = 1'($urandom_range(0, 1));
            i_line_data   = {8{$urandom()}};
            @(negedge clk);
            check("idle_busy", o_fetch_busy, 0);
            check("idle_ready", o_line_ready, 0);
            check("idle_wr_en", o_wr_en, 0);
            check("idle_al_en", {o_left_exp_aligned_wr_en, o_right_exp_aligned_wr_en}, 0);
            @(posedge clk);
            #1;
        end
    endtask

    // Model: ready is high from cycle 1 until 528 beats are taken, so a beat is accepted
    // whenever valid is driven then. Line n is written one cycle after acceptance; aligned
    // write k lands at acc15+3+k; done = max(acc527+3, acc15+515).
    task automatic run_fetch(input bit tgt, input bit patterned, input int stall_beat,
                             input int stall_len, input bit rand_stall, input int restart_cyc,
                             input int reset_cyc, input int want_done, input bit a5_check);
        int acc[528];
        int nacc, wr_line, a15, done_c, stall_left, n_wr, n_al, obs_done, k, r;
        bit stall_used, v, acc_now, exp_ready, exp_busy, aborted;
        logic [DW-1:0] tmp;
        logic [7:0] eb;
        nacc = 0; wr_line = -1; a15 = -1; done_c = -1; stall_left = 0;
        n_wr = 0; n_al = 0; obs_done = -1; stall_used = 0; aborted = 0;
        for (int i = 0; i < 528; i++) begin
            if (patterned) lines[i] = {32{i[7:0]}};
            else           lines[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                                       $urandom(), $urandom(), $urandom(), $urandom()};
        end
        if (a5_check) lines[3][47:40] = 8'hA5;

        for (int c = 0; c < 1500; c++) begin
            i_fetch_start  = (c == 0) || (c == restart_cyc);
            i_fetch_target = (c == 0) ? tgt : ~tgt;
            v = 1'b1;
            if (c >= 1 && nacc < 528) begin
                if (nacc == stall_beat && !stall_used) begin
                    stall_left = stall_len;
                    stall_used = 1'b1;
                end
                if (stall_left > 0) begin
                    v = 1'b0;
                    stall_left--;
                end else if (rand_stall && $urandom_range(0, 5) == 0) begin
                    v = 1'b0;
                end
            end else begin
                v = 1'($urandom_range(0, 1));
            end
            i_line_valid = v;
            i_line_data  = (nacc < 528) ? lines[nacc] : {8{$urandom()}};
            if (c == reset_cyc) i_reset = 1'b1;
            @(negedge clk);
            if (c == reset_cyc) begin
                check_zero("rst_mid");
                aborted = 1'b1;
                break;
            end
            exp_busy  = (c >= 1) && (done_c < 0 || c < done_c);
            exp_ready = (c >= 1) && (nacc < 528);
            check("busy", o_fetch_busy, exp_busy);
            check("ready", o_line_ready, exp_ready);
            check("done", o_fetch_done, c == done_c);
            check("wr_en", o_wr_en, wr_line >= 0);
            if (wr_line >= 0) begin
                check("wr_addr", o_wr_addr, wr_line);
                check("wr_data", o_wr_data, lines[wr_line]);
                check("wr_target", o_wr_target, tgt);
            end
            k = (a15 >= 0) ? c - (a15 + 3) : -1;
            check("left_en", o_left_exp_aligned_wr_en, (k >= 0 && k < 512 && !tgt));
            check("right_en", o_right_exp_aligned_wr_en, (k >= 0 && k < 512 && tgt));
            if (k >= 0 && k < 512) begin
                tmp = lines[k / 32];
                eb  = tmp[(k % 32) * 8 +: 8];
                if (tgt) begin
                    check("al_addr", o_right_exp_aligned_wr_addr, k);
                    check("al_data", o_right_exp_aligned_wr_data, eb);
                    if (a5_check && k == 101) check("al101", o_right_exp_aligned_wr_data, 8'hA5);
                end else begin
                    check("al_addr", o_left_exp_aligned_wr_addr, k);
                    check("al_data", o_left_exp_aligned_wr_data, eb);
                end
            end
            r = (a15 >= 0) ? c - (a15 + 2) : -1;
            if (r >= 0 && r < 512) check("rd_addr", o_exp_packed_rd_addr, r / 32);
            if (exp_busy) check("rd_target", o_exp_packed_rd_target, tgt);
            n_wr += int'(o_wr_en);
            n_al += int'(o_left_exp_aligned_wr_en | o_right_exp_aligned_wr_en);
            if (o_fetch_done === 1'b1 && obs_done < 0) obs_done = c;
            acc_now = v && exp_ready;
            @(posedge clk);
            #1;
            if (c == done_c) break;
            wr_line = -1;
            if (acc_now) begin
                acc[nacc] = c;
                wr_line   = nacc;
                if (nacc == 15) a15 = c;
                nacc++;
                if (nacc == 528)
                    done_c = (acc[527] + 3 > a15 + 515) ? acc[527] + 3 : a15 + 515;
            end
        end

        i_fetch_start = 1'b0;
        if (aborted) begin
            for (int i = 0; i < 2; i++) begin
                @(posedge clk);
                #1;
                i_line_valid = 1'b1;
                @(negedge clk);
                check_zero("rst_hold");
            end
            @(posedge clk);
            #1;
            i_reset = 1'b0;
            idle_cycles(2);
        end else begin
            check("done_seen", obs_done >= 0, 1);
            check("n_wr_en", n_wr, 528);
            check("n_aligned", n_al, 512);
            if (want_done >= 0) check("done_cycle", obs_done, want_done);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) bram_exp[s][i] = '0;
        i_reset        = 1'b1;
        i_fetch_start  = 1'b0;
        i_fetch_target = 1'b0;
        i_line_valid   = 1'b0;
        i_line_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("rst_init");
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        idle_cycles(3);

        run_fetch(1'b0, 1'b1, -1, 0, 1'b0, -1, -1, 531, 1'b0);
        idle_cycles(2);
        run_fetch(1'b1, 1'b0, -1, 0, 1'b0, -1, -1, 531, 1'b1);
        run_fetch(1'b0, 1'b0, 201, 10, 1'b0, -1, -1, 541, 1'b0);
        run_fetch(1'b1, 1'b0, 10, 4, 1'b0, -1, -1, 535, 1'b0);
        idle_cycles(1);
        run_fetch(1'b0, 1'b0, -1, 0, 1'b0, 100, -1, 531, 1'b0);
        run_fetch(1'b1, 1'b0, -1, 0, 1'b0, -1, 300, -1, 1'b0);
        run_fetch(1'b1, 1'b1, -1, 0, 1'b0, -1, -1, 531, 1'b0);
        for (int t = 0; t < 2; t++)
            run_fetch(1'($urandom_range(0, 1)), 1'b0, -1, 0, 1'b1, -1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
